trg_pls_sched: RTL and testbench
================================

TRG_PLS_SCHED -- requirements
Module: trg_pls_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of trigger channels.
REQ-002 SHALL have parameter FRAME_LAST, default 510, last timebase count of a firing frame.
REQ-003 SHALL have port CLK160M  input  1  160 MHz system clock; all logic is rising-edge.
REQ-004 SHALL have port RESET_N  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port REG_WE  input  1  one-cycle register write strobe from the SPI command decoder.
REQ-006 SHALL have port REG_ADDR  input  8  register address for write and read.
REQ-007 SHALL have port REG_WDATA  input  8  write data.
REQ-008 SHALL have port REG_RDATA  output  8  combinational read data for REG_ADDR.
REQ-009 SHALL have port START  input  1  one-cycle fire request.
REQ-010 SHALL have port ABORT  input  1  one-cycle abort request.
REQ-011 SHALL have port TRG_PLS  output  NUM_CH  registered trigger pulses.
REQ-012 SHALL have port BUSY  output  1  high while a frame runs.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse at frame end.

Function
REQ-014 SHALL hold shadow registers: DLY[ch] at 0x10+ch, WID[ch] at 0x20+ch (8 bit each), EN mask[4:0] at 0x30.
REQ-015 SHALL update a shadow register on the edge where REG_WE=1; writes to unmapped addresses are ignored.
REQ-016 SHALL return a shadow value on REG_RDATA for mapped addresses; 0x3F returns {6'b0, ERR, BUSY}; unmapped addresses return 0x00.
REQ-017 SHALL clear ERR on any write to 0x3F; a simultaneous set event takes priority over the clear.
REQ-018 SHALL implement FSM IDLE -> RUN -> IDLE; BUSY = (state==RUN).
REQ-019 In IDLE, START=1 SHALL copy all shadow registers into active registers, clear the 9-bit timebase CNT to 0, and enter RUN.
REQ-020 In RUN, CNT SHALL increment by 1 per cycle; on the cycle CNT==FRAME_LAST the FSM SHALL return to IDLE and assert DONE for exactly one cycle.
REQ-021 TRG_PLS[ch] SHALL be the registered value of (RUN && EN[ch] && DLY[ch] <= CNT < DLY[ch]+WID[ch]), with the sum computed at 9 bits and no wrap.
REQ-022 Latency: for START sampled at edge k, TRG_PLS[ch] SHALL rise at edge k+2+DLY[ch] and stay high for exactly WID[ch] cycles.
REQ-023 WID[ch]=0 or EN[ch]=0 SHALL produce no pulse on that channel.
REQ-024 Shadow writes during RUN SHALL NOT affect the running frame and SHALL take effect at the next START.
REQ-025 START during RUN SHALL be ignored and SHALL set ERR.
REQ-026 ABORT in RUN SHALL return the FSM to IDLE on that edge, drive TRG_PLS to 0 on the next edge, and SHALL NOT assert DONE.
REQ-027 When ABORT and START are asserted in the same cycle, ABORT SHALL win; START in IDLE with ABORT high SHALL be ignored.
REQ-028 A START in the cycle in which DONE is asserted SHALL be accepted, because the FSM is already IDLE.

Reset
REQ-029 While RESET_N=1 the block SHALL force state=IDLE, CNT=0, TRG_PLS=0, BUSY=0, DONE=0, ERR=0, all shadow and active registers=0, asynchronously.
REQ-030 Reset asserted mid-frame SHALL drop TRG_PLS without waiting for a clock edge; operation resumes only after RESET_N=0 and a new START.

Structure
REQ-031 SHALL take register addresses, NUM_CH, and the FSM state enum from shared package ptmch_pkg.
REQ-032 SHALL instantiate sub-module trg_pls_chan NUM_CH times; each instance holds the active DLY/WID/EN and the registered comparator for one channel.

Verification
REQ-033 Program DLY0=0x00, WID0=0x04, EN=0x01, then START -> TRG_PLS[0] high on edges k+2..k+5, DONE at CNT==510, BUSY low afterwards.
REQ-034 Program all channels DLY=0x10*ch+1, WID=0x08, EN=0x1F, then START -> five non-overlapping 8-cycle pulses starting at k+3, k+19, k+35, k+51, k+67.
REQ-035 Set DLY1=0xFF, WID1=0xFF, EN=0x02, then START -> pulse on edges k+257..k+511, no wrap, no pulse after DONE.
REQ-036 Write WID0=0x02 mid-frame, then issue a second START during RUN -> first frame unchanged, read 0x3F = 0x03; next frame uses WID0=2.
REQ-037 Issue ABORT at CNT=5 while DLY0=0, WID0=0x20 -> TRG_PLS[0] low one edge later, no DONE pulse, BUSY=0.
REQ-038 Assert RESET_N=1 for 20 ns mid-pulse -> TRG_PLS=0 immediately and all registers read back 0x00.

Source files
------------

// File: rtl/ptmch_pkg.sv
// Shared definitions for the trigger pulse scheduler: register map, channel count,
// timebase width and FSM state encoding.
package ptmch_pkg;

   localparam int         PTM_NUM_CH    = 5;
   localparam int         CNT_W         = 9;

   localparam logic [7:0] ADDR_DLY_BASE = 8'h10;
   localparam logic [7:0] ADDR_WID_BASE = 8'h20;
   localparam logic [7:0] ADDR_EN       = 8'h30;
   localparam logic [7:0] ADDR_STAT     = 8'h3F;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic logic is_ch_addr(input logic [7:0] addr, input logic [7:0] base, input int ch);
      return addr == (base + 8'(ch));
   endfunction

endpackage

// File: rtl/trg_pls_chan.sv
// One trigger channel: active DLY/WID/EN captured at frame start plus the registered
// window comparator against the shared timebase.
module trg_pls_chan
   import ptmch_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [7:0]       dly_sh,
   input  logic [7:0]       wid_sh,
   input  logic             en_sh,
   input  logic             run,
   input  logic [CNT_W-1:0] cnt,
   output logic             hit
);

   logic [7:0]       dly_q, dly_d;
   logic [7:0]       wid_q, wid_d;
   logic             en_q, en_d;
   logic             hit_q, hit_d;
   logic [CNT_W-1:0] win_end_s;

   // Active settings are frozen for the whole frame; only a frame start reloads them
   always_comb begin
      if (load) begin
         dly_d = dly_sh;
         wid_d = wid_sh;
         en_d  = en_sh;
      end else begin
         dly_d = dly_q;
         wid_d = wid_q;
         en_d  = en_q;
      end
   end

   // Window end is computed at timebase width so DLY+WID never wraps
   always_comb begin
      win_end_s = CNT_W'(dly_q) + CNT_W'(wid_q);
      hit_d     = run & en_q & (cnt >= CNT_W'(dly_q)) & (cnt < win_end_s);
   end

   // Channel state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dly_q <= 8'h00;
         wid_q <= 8'h00;
         en_q  <= 1'b0;
         hit_q <= 1'b0;
      end else begin
         dly_q <= dly_d;
         wid_q <= wid_d;
         en_q  <= en_d;
         hit_q <= hit_d;
      end
   end

   assign hit = hit_q;

endmodule

// File: rtl/trg_pls_sched.sv
// Trigger pulse scheduler: SPI-programmed shadow registers, a fixed-length firing frame
// driven by a 9-bit timebase, and NUM_CH delayed/width-controlled trigger pulses.
module trg_pls_sched
   import ptmch_pkg::*;
#(
   parameter int NUM_CH     = PTM_NUM_CH,
   parameter int FRAME_LAST = 510
) (
   input  logic              CLK160M,
   input  logic              RESET_N,
   input  logic              REG_WE,
   input  logic [7:0]        REG_ADDR,
   input  logic [7:0]        REG_WDATA,
   output logic [7:0]        REG_RDATA,
   input  logic              START,
   input  logic              ABORT,
   output logic [NUM_CH-1:0] TRG_PLS,
   output logic              BUSY,
   output logic              DONE
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        dly_q [NUM_CH];
   logic [7:0]        dly_d [NUM_CH];
   logic [7:0]        wid_q [NUM_CH];
   logic [7:0]        wid_d [NUM_CH];
   logic [NUM_CH-1:0] en_q, en_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic [NUM_CH-1:0] trg_q, trg_d;
   logic [NUM_CH-1:0] hit_s;
   logic              run_s, accept_s, frame_end_s, err_set_s, err_clr_s;

   // Next-state: ABORT beats START, and beats the natural frame end
   always_comb begin
      state_d     = state_q;
      accept_s    = 1'b0;
      frame_end_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (START && !ABORT) begin
               state_d  = ST_RUN;
               accept_s = 1'b1;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (ABORT) begin
               state_d     = ST_IDLE;
            end else if (cnt_q == CNT_W'(FRAME_LAST)) begin
               state_d     = ST_IDLE;
               frame_end_s = 1'b1;
            end else begin
               state_d     = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs and timebase
   always_comb begin
      run_s  = (state_q == ST_RUN);
      done_d = frame_end_s;
      if (accept_s) begin
         cnt_d = '0;
      end else if (run_s) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
      // A pulse may only leave the block while the frame is still running
      trg_d = hit_s & {NUM_CH{run_s}};
   end

   // Shadow register writes and the sticky error flag (set wins over clear)
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         dly_d[i] = (REG_WE && is_ch_addr(REG_ADDR, ADDR_DLY_BASE, i)) ? REG_WDATA : dly_q[i];
         wid_d[i] = (REG_WE && is_ch_addr(REG_ADDR, ADDR_WID_BASE, i)) ? REG_WDATA : wid_q[i];
      end
      en_d      = (REG_WE && (REG_ADDR == ADDR_EN)) ? REG_WDATA[NUM_CH-1:0] : en_q;
      err_set_s = START & run_s & ~ABORT;
      err_clr_s = REG_WE & (REG_ADDR == ADDR_STAT);
      if (err_set_s) begin
         err_d = 1'b1;
      end else if (err_clr_s) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // Combinational register read-back; unmapped addresses read as zero
   always_comb begin
      REG_RDATA = 8'h00;
      for (int i = 0; i < NUM_CH; i++) begin
         REG_RDATA = REG_RDATA
                   | (is_ch_addr(REG_ADDR, ADDR_DLY_BASE, i) ? dly_q[i] : 8'h00)
                   | (is_ch_addr(REG_ADDR, ADDR_WID_BASE, i) ? wid_q[i] : 8'h00);
      end
      REG_RDATA = REG_RDATA
                | ((REG_ADDR == ADDR_EN)   ? 8'(en_q) : 8'h00)
                | ((REG_ADDR == ADDR_STAT) ? {6'b000000, err_q, run_s} : 8'h00);
   end

   // State, timebase, shadow and output registers
   always_ff @(posedge CLK160M or posedge RESET_N) begin
      if (RESET_N) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         en_q    <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         trg_q   <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            dly_q[i] <= 8'h00;
            wid_q[i] <= 8'h00;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         err_q   <= err_d;
         done_q  <= done_d;
         trg_q   <= trg_d;
         for (int i = 0; i < NUM_CH; i++) begin
            dly_q[i] <= dly_d[i];
            wid_q[i] <= wid_d[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      trg_pls_chan u_chan (
         .clk    (CLK160M),
         .rst    (RESET_N),
         .load   (accept_s),
         .dly_sh (dly_q[g]),
         .wid_sh (wid_q[g]),
         .en_sh  (en_q[g]),
         .run    (run_s),
         .cnt    (cnt_q),
         .hit    (hit_s[g])
      );
   end

   assign TRG_PLS = trg_q;
   assign BUSY    = run_s;
   assign DONE    = done_q;

endmodule

// File: tb/tb_trg_pls_sched.sv
// Scoreboard bench for trg_pls_sched: a frame-level model predicts whole pulses, DONE
// edges and read-back values; a negedge monitor pops and compares them.
`timescale 1ns/100ps
module tb_trg_pls_sched;

   localparam int NCH   = 5;
   localparam int FLAST = 510;

   typedef struct {
      int rise;
      int width;
   } pls_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           we = 1'b0;
   logic [7:0]     addr = 8'h00;
   logic [7:0]     wdata = 8'h00;
   logic           start = 1'b0;
   logic           abort = 1'b0;
   logic [7:0]     rdata;
   logic [NCH-1:0] trg;
   logic           busy;
   logic           done;

   int checks = 0;
   int failures = 0;
   int edge_cnt = 0;
   bit mon_en = 1'b0;

   // reference model state
   logic [7:0]     m_dly [NCH];
   logic [7:0]     m_wid [NCH];
   logic [NCH-1:0] m_en;
   bit             m_err;
   bit             m_busy;
   int             m_k;

   pls_t       exp_q [NCH][$];
   int         done_q [$];
   logic [7:0] rd_q [$];

   trg_pls_sched #(.NUM_CH(NCH), .FRAME_LAST(FLAST)) dut (
      .CLK160M  (clk),
      .RESET_N  (rst),
      .REG_WE   (we),
      .REG_ADDR (addr),
      .REG_WDATA(wdata),
      .REG_RDATA(rdata),
      .START    (start),
      .ABORT    (abort),
      .TRG_PLS  (trg),
      .BUSY     (busy),
      .DONE     (done)
   );

   always #3 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   function automatic logic [7:0] m_read(input logic [7:0] a);
      for (int c = 0; c < NCH; c++) begin
         if (a == 8'h10 + 8'(c)) return m_dly[c];
         if (a == 8'h20 + 8'(c)) return m_wid[c];
      end
      if (a == 8'h30) return 8'(m_en);
      if (a == 8'h3F) return {6'b000000, m_err, m_busy};
      return 8'h00;
   endfunction

   task automatic m_reset();
      for (int c = 0; c < NCH; c++) begin
         m_dly[c] = 8'h00;
         m_wid[c] = 8'h00;
         exp_q[c].delete();
      end
      m_en   = '0;
      m_err  = 1'b0;
      m_busy = 1'b0;
      m_k    = 0;
      done_q.delete();
      rd_q.delete();
   endtask

   // frame-level model of what edge e does
   task automatic m_edge(input int e, input bit w, input logic [7:0] a, input logic [7:0] d,
                         input bit st, input bit ab);
      bit   set_e;
      pls_t p;
      int   last;
      set_e = 1'b0;
      if (m_busy) begin
         if (ab) begin
            for (int c = 0; c < NCH; c++) begin
               if (exp_q[c].size() > 0) begin
                  last = exp_q[c].size() - 1;
                  if (exp_q[c][last].rise > e)
                     void'(exp_q[c].pop_back());
                  else if (exp_q[c][last].rise + exp_q[c][last].width - 1 > e)
                     exp_q[c][last].width = e - exp_q[c][last].rise + 1;
               end
            end
            if (done_q.size() > 0) void'(done_q.pop_back());
            m_busy = 1'b0;
         end else begin
            if (st) set_e = 1'b1;
            if (e == m_k + FLAST + 1) m_busy = 1'b0;
         end
      end else if (st && !ab) begin
         m_busy = 1'b1;
         m_k    = e;
         for (int c = 0; c < NCH; c++) begin
            if (m_en[c] && m_wid[c] != 8'h00) begin
               p.rise  = e + 2 + int'(m_dly[c]);
               p.width = int'(m_wid[c]);
               exp_q[c].push_back(p);
            end
         end
         done_q.push_back(e + FLAST + 1);
      end
      if (w) begin
         for (int c = 0; c < NCH; c++) begin
            if (a == 8'h10 + 8'(c)) m_dly[c] = d;
            if (a == 8'h20 + 8'(c)) m_wid[c] = d;
         end
         if (a == 8'h30) m_en = d[NCH-1:0];
      end
      if (set_e) m_err = 1'b1;
      else if (w && a == 8'h3F) m_err = 1'b0;
   endtask

   task automatic step(input bit w, input logic [7:0] a, input logic [7:0] d, input bit st, input bit ab);
      @(posedge clk);
      #1;
      we = w; addr = a; wdata = d; start = st; abort = ab;
      rd_q.push_back(m_read(a));
      m_edge(edge_cnt + 1, w, a, d, st, ab);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      step(1'b1, a, d, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h3F, 8'h00, 1'b0, 1'b0);
   endtask

   // monitor: pops expected pulses on each falling edge, DONE and read-back every cycle
   int   rise_at [NCH];
   bit   prev [NCH];
   pls_t mp;
   int   md;
   logic [7:0] mr;
   always @(negedge clk) begin
      if (mon_en) begin
         for (int c = 0; c < NCH; c++) begin
            if (trg[c] && !prev[c]) begin
               rise_at[c] = edge_cnt;
            end else if (!trg[c] && prev[c]) begin
               if (exp_q[c].size() == 0) begin
                  check($sformatf("pls_unexpected_ch%0d_rise", c), rise_at[c], -1);
               end else begin
                  mp = exp_q[c].pop_front();
                  check($sformatf("pls_rise_ch%0d", c), rise_at[c], mp.rise);
                  check($sformatf("pls_width_ch%0d", c), edge_cnt - rise_at[c], mp.width);
               end
            end
            prev[c] = trg[c];
         end
         if (done) begin
            if (done_q.size() == 0) begin
               check("done_unexpected_edge", edge_cnt, -1);
            end else begin
               md = done_q.pop_front();
               check("done_edge", edge_cnt, md);
            end
            check("busy_after_done", int'(busy), 0);
         end
         if (rd_q.size() > 0) begin
            mr = rd_q.pop_front();
            check($sformatf("rdata_addr%0h", addr), int'(rdata), int'(mr));
         end
      end else begin
         for (int c = 0; c < NCH; c++) prev[c] = 1'b0;
      end
   end

   initial begin
      bit         w, st, ab;
      logic [7:0] a;
      int         r;
      m_reset();
      #10;
      check("reset_trg", int'(trg), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      addr = 8'h3F;
      #1;
      check("reset_stat", int'(rdata), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;

      // single short pulse, full frame, DONE
      wr(8'h10, 8'h00); wr(8'h20, 8'h04); wr(8'h30, 8'h01);
      step(1'b0, 8'h3F, 8'h00, 1'b1, 1'b0);
      idle(520);

      // five staggered channels
      for (int c = 0; c < NCH; c++) begin
         wr(8'h10 + 8'(c), 8'(16 * c + 1));
         wr(8'h20 + 8'(c), 8'h08);
      end
      wr(8'h30, 8'h1F);
      step(1'b0, 8'h3F, 8'h00, 1'b1, 1'b0);
      idle(520);

      // longest window, ends exactly at frame end
      wr(8'h11, 8'hFF); wr(8'h21, 8'hFF); wr(8'h30, 8'h02);
      step(1'b0, 8'h3F, 8'h00, 1'b1, 1'b0);
      idle(520);

      // mid-frame shadow write, START in RUN sets ERR, set beats clear, next frame uses new WID
      wr(8'h10, 8'h00); wr(8'h20, 8'h06); wr(8'h30, 8'h01);
      step(1'b0, 8'h3F, 8'h00, 1'b1, 1'b0);
      idle(3);
      wr(8'h20, 8'h02);
      step(1'b0, 8'h3F, 8'h00, 1'b1, 1'b0);
      idle(2);
      check("stat_err_busy", int'(rdata), 8'h03);
      step(1'b1, 8'h3F, 8'h00, 1'b1, 1'b0);
      idle(520);
      wr(8'h3F, 8'h00);
      step(1'b0, 8'h3F, 8'h00, 1'b1, 1'b0);
      idle(520);

      // abort at CNT=5, and ABORT beating START in IDLE
      wr(8'h20, 8'h20);
      step(1'b0, 8'h3F, 8'h00, 1'b1, 1'b0);
      idle(5);
      step(1'b0, 8'h3F, 8'h00, 1'b0, 1'b1);
      idle(3);
      step(1'b0, 8'h3F, 8'h00, 1'b1, 1'b1);
      idle(40);

      // randomized traffic
      for (int i = 0; i < 12000; i++) begin
         r  = $urandom_range(0, 15);
         w  = ($urandom_range(0, 9) == 0);
         if (r < 5)       a = 8'h10 + 8'(r);
         else if (r < 10) a = 8'h20 + 8'(r - 5);
         else if (r == 10) a = 8'h30;
         else if (r == 11) a = 8'h3F;
         else             a = 8'($urandom_range(0, 255));
         st = m_busy ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 3) == 0);
         ab = ($urandom_range(0, 399) == 0);
         step(w, a, 8'($urandom_range(0, 255)), st, ab);
      end
      idle(600);

      // asynchronous reset in the middle of a pulse
      wr(8'h10, 8'h00); wr(8'h20, 8'h40); wr(8'h30, 8'h01);
      step(1'b0, 8'h3F, 8'h00, 1'b1, 1'b0);
      idle(10);
      mon_en = 1'b0;
      check("pre_reset_trg0", int'(trg[0]), 1);
      #1;
      rst = 1'b1;
      #0.5;
      check("async_reset_trg", int'(trg), 0);
      check("async_reset_busy", int'(busy), 0);
      check("async_reset_done", int'(done), 0);
      #20;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_reset();
      mon_en = 1'b1;
      for (int c = 0; c < NCH; c++) begin
         step(1'b0, 8'h10 + 8'(c), 8'h00, 1'b0, 1'b0);
         step(1'b0, 8'h20 + 8'(c), 8'h00, 1'b0, 1'b0);
      end
      step(1'b0, 8'h30, 8'h00, 1'b0, 1'b0);
      idle(20);

      for (int c = 0; c < NCH; c++) check($sformatf("pending_pulses_ch%0d", c), exp_q[c].size(), 0);
      check("pending_done", done_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
